// File: rtl/ok_btpipe_out_source.sv
// Block-throttled pipe-out data source: user words are buffered in a FIFO.
// ep_ready is raised once a full host block is buffered.
module ok_btpipe_out_source #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  okClk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  full,
  input  logic                  ep_blockstrobe,
  input  logic                  ep_read,
  output logic [31:0]           ep_datain,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  clr_flags,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  protocol_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int WLW   = $clog2(BLOCK_WORDS + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  BLK_C   = CW'(BLOCK_WORDS);
  localparam logic [WLW-1:0] BLK_WL  = WLW'(BLOCK_WORDS);

  typedef enum logic {IDLE, BLOCK} state_t;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  state_t                state, state_next;
  logic [WLW-1:0]        words_left, words_left_next;
  logic                  wr_acc, rd_acc, proto_set;
  logic [CW-1:0]         count_next;

  // full comes from the registered count, so a same-edge read never frees room
  assign full       = (count == DEPTH_C);
  assign wr_acc     = wr_en && !full;
  assign rd_acc     = ep_read && (count != '0);
  assign count_next = count + CW'(wr_acc) - CW'(rd_acc);

  always_comb begin
    state_next      = state;
    words_left_next = words_left;
    proto_set       = 1'b0;
    case (state)
      IDLE: begin
        if (ep_read) proto_set = 1'b1;
        if (ep_blockstrobe) begin
          if (ep_ready) begin
            state_next      = BLOCK;
            words_left_next = BLK_WL;
          end else begin
            proto_set = 1'b1;
          end
        end
      end
      BLOCK: begin
        if (ep_blockstrobe) proto_set = 1'b1;
        if (ep_read) begin
          if (words_left <= WLW'(1)) begin
            words_left_next = '0;
            state_next      = IDLE;
          end else begin
            words_left_next = words_left - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // storage has no reset; contents are meaningless until written
  always_ff @(posedge okClk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ep_datain    <= '0;
      ep_ready     <= 1'b0;
      state        <= IDLE;
      words_left   <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (ep_read) begin
        if (rd_acc) begin
          ep_datain <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + 1'b1;
        end else begin
          ep_datain <= '0;
        end
      end
      count      <= count_next;
      state      <= state_next;
      words_left <= words_left_next;
      ep_ready   <= (state_next == IDLE) && (count_next >= BLK_C);
      if (clr_flags) begin
        overflow     <= 1'b0;
        underflow    <= 1'b0;
        protocol_err <= 1'b0;
      end else begin
        if (wr_en && full)         overflow     <= 1'b1;
        if (ep_read && !rd_acc)    underflow    <= 1'b1;
        if (proto_set)             protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ok_btpipe_out_source.sv
// Directed bench for ok_btpipe_out_source; read data is checked by a
// scoreboard monitor decoupled from the stimulus.
module tb_ok_btpipe_out_source;

  logic        okClk = 1'b0;
  logic        reset;
  logic        wr_en, ep_blockstrobe, ep_read, clr_flags;
  logic [31:0] wr_data;
  logic        full, ep_ready, overflow, underflow, protocol_err;
  logic [31:0] ep_datain;
  logic [10:0] count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_q[$];
  logic [31:0] sb_q[$];
  logic        rd_seen;
  logic [31:0] exp_w;

  ok_btpipe_out_source #(.DEPTH_LOG2(10), .BLOCK_WORDS(256)) dut (
    .okClk(okClk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .ep_blockstrobe(ep_blockstrobe), .ep_read(ep_read),
    .ep_datain(ep_datain), .ep_ready(ep_ready), .count(count),
    .clr_flags(clr_flags), .overflow(overflow), .underflow(underflow),
    .protocol_err(protocol_err)
  );

  always #5 okClk = ~okClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: a read taken on an edge is compared at the following negedge
  always @(posedge okClk or posedge reset)
    if (reset) rd_seen <= 1'b0;
    else       rd_seen <= ep_read;

  always @(negedge okClk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underrun actual=%0h required=none", ep_datain);
      end else begin
        exp_w = sb_q.pop_front();
        chk("ep_datain", ep_datain, exp_w);
      end
    end
  end

  // one clock of stimulus; the model decides acceptance from its own occupancy
  task automatic cyc(input bit we, input logic [31:0] wd, input bit rd, input bit bs, input bit clr);
    bit wr_ok;
    wr_ok = we && (model_q.size() < 1024);
    if (rd) begin
      if (model_q.size() > 0) sb_q.push_back(model_q.pop_front());
      else                    sb_q.push_back(32'h0);
    end
    if (wr_ok) model_q.push_back(wd);
    wr_en = we; wr_data = wd; ep_read = rd; ep_blockstrobe = bs; clr_flags = clr;
    @(posedge okClk); #1;
    wr_en = 0; wr_data = 0; ep_read = 0; ep_blockstrobe = 0; clr_flags = 0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) cyc(1, base + i, 0, 0, 0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0);
  endtask

  task automatic run_block();
    cyc(0, 0, 0, 1, 0);
    chk("ready_drop_on_strobe", ep_ready, 0);
    read_n(256);
  endtask

  task automatic do_reset();
    reset = 1;
    #3;
    chk("rst_count", count, 0);
    chk("rst_ready", ep_ready, 0);
    chk("rst_datain", ep_datain, 0);
    chk("rst_full", full, 0);
    chk("rst_flags", {overflow, underflow, protocol_err}, 0);
    model_q.delete();
    sb_q.delete();
    @(posedge okClk); #1;
    reset = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_en = 0; wr_data = 0; ep_read = 0; ep_blockstrobe = 0; clr_flags = 0;
    do_reset();

    // basic block
    push_n(255, 0);
    chk("t1_ready_255", ep_ready, 0);
    cyc(1, 255, 0, 0, 0);
    chk("t1_ready_256", ep_ready, 1);
    cyc(0, 0, 0, 0, 0);
    run_block();
    chk("t1_ready_end", ep_ready, 0);
    chk("t1_count_end", count, 0);
    chk("t1_flags", {overflow, underflow, protocol_err}, 0);

    // two blocks out of 600 words
    do_reset();
    push_n(600, 32'h0000_1000);
    chk("t2_count", count, 600);
    chk("t2_ready", ep_ready, 1);
    run_block();
    chk("t2_ready_reassert", ep_ready, 1);
    run_block();
    chk("t2_count_end", count, 88);
    chk("t2_ready_end", ep_ready, 0);
    chk("t2_proto", protocol_err, 0);

    // full / overflow, including a write rejected on a read edge
    do_reset();
    push_n(1024, 32'h0000_5000);
    chk("t3_full", full, 1);
    chk("t3_count_full", count, 1024);
    chk("t3_no_ovf", overflow, 0);
    cyc(1, 32'hDEAD_0001, 0, 0, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_count_hold", count, 1024);
    cyc(0, 0, 0, 0, 1);
    chk("t3_ovf_clr", overflow, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'hDEAD_0002, 1, 0, 0);
    chk("t3_ovf_on_read", overflow, 1);
    chk("t3_count_1023", count, 1023);
    read_n(255);
    run_block();
    run_block();
    run_block();
    chk("t3_count_end", count, 0);
    chk("t3_full_end", full, 0);

    // underflow / protocol (ep_datain is nonzero entering this test)
    cyc(0, 0, 0, 0, 1);
    chk("t4_clr", {overflow, underflow, protocol_err}, 0);
    cyc(0, 0, 1, 0, 0);
    chk("t4_underflow", underflow, 1);
    chk("t4_count0", count, 0);
    push_n(10, 32'h0000_A000);
    cyc(0, 0, 0, 1, 0);
    chk("t4_proto_strobe", protocol_err, 1);
    chk("t4_ready_10", ep_ready, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_clr2", {underflow, protocol_err}, 0);
    push_n(246, 32'h0000_A00A);
    chk("t4_still_idle", ep_ready, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("t4_clr_priority", protocol_err, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_proto_in_block", protocol_err, 1);
    cyc(0, 0, 0, 0, 1);
    read_n(256);
    chk("t4_no_proto", protocol_err, 0);
    chk("t4_count_end", count, 0);
    push_n(256, 32'h0000_B000);
    chk("t4_back_idle", ep_ready, 1);

    // simultaneous write/read with write-pointer wrap, then read-pointer wrap
    do_reset();
    push_n(1000, 32'h1000_0000);
    run_block();
    chk("t5_ready", ep_ready, 1);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 50; i++) begin
      cyc(1, 32'h2000_0000 + i, 1, 0, 0);
      chk("t5_count_const", count, 744);
    end
    read_n(206);
    run_block();
    run_block();
    chk("t5_count_26", count, 26);
    chk("t5_ready_26", ep_ready, 0);
    read_n(26);
    chk("t5_count_end", count, 0);

    // asynchronous reset mid-block
    do_reset();
    push_n(256, 32'hC000_0000);
    cyc(0, 0, 0, 1, 0);
    read_n(100);
    cyc(0, 0, 0, 0, 0);
    #2;
    reset = 1;
    #1;
    chk("t6_async_ready", ep_ready, 0);
    chk("t6_async_count", count, 0);
    chk("t6_async_datain", ep_datain, 0);
    model_q.delete();
    sb_q.delete();
    @(posedge okClk); #1;
    reset = 0;
    push_n(256, 32'hD000_0000);
    chk("t6_ready_again", ep_ready, 1);
    run_block();
    chk("t6_count_end", count, 0);
    chk("t6_ready_end", ep_ready, 0);

    repeat (3) @(posedge okClk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ok_btpipe_out_source.md
Name: ok_btpipe_out_source

Overview:
- User-side data source for a block-throttled pipe-out endpoint. It is the transmitter for the host's block reads.
- User logic pushes 32-bit words into an internal FIFO.
- The block raises ep_ready once a full block is buffered, then returns words one per ep_read to the endpoint, tracking block boundaries.
- It sits between user logic and a BTPipeOut on the okClk domain, in both the single-host and dual-host simulation setups.

Parameters:
- DEPTH_LOG2, 10, FIFO depth is 2^DEPTH_LOG2 words.
- BLOCK_WORDS, 256, words per host block transfer. Must be ≥1 and ≤ 2^DEPTH_LOG2.

Ports:
- okClk  input  1  sole clock. All logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  user push strobe.
- wr_data  input  32  user push data.
- full  output  1  FIFO full (count == 2^DEPTH_LOG2).
- ep_blockstrobe  input  1  one-cycle pulse marking the start of a host block.
- ep_read  input  1  host read request. The word is taken on the following cycle.
- ep_datain  output  32  read data to the endpoint.
- ep_ready  output  1  a full block is available.
- count  output  DEPTH_LOG2+1  current FIFO occupancy.
- clr_flags  input  1  synchronous clear of the sticky flags.
- overflow  output  1  sticky: a write was dropped because the FIFO was full.
- underflow  output  1  sticky: ep_read arrived while the FIFO was empty.
- protocol_err  output  1  sticky: a host sequencing violation occurred.

Behaviour:
- Reset (asynchronous, any time including mid-block):
  - All outputs go to 0, with full=0, count=0 and ep_datain=0.
  - Pointers are cleared, the state goes to IDLE and words_left=0.
  - FIFO memory contents are don't-care.
- Write:
  - wr_en && !full: mem[wr_ptr]<=wr_data and wr_ptr increments, wrapping modulo 2^DEPTH_LOG2.
  - wr_en && full: the word is dropped, overflow is set and pointers are unchanged.
- Read (latency 1):
  - Edge with ep_read && count>0: ep_datain<=mem[rd_ptr] and rd_ptr increments with wrap.
  - Edge with ep_read && count==0: ep_datain<=0, underflow is set and rd_ptr is unchanged.
  - With no ep_read, ep_datain holds its last value.
- Count:
  - count_next = count + (accepted write) − (accepted read).
  - A simultaneous accepted write and read leaves count unchanged.
  - A write when full is rejected even if a read occurs on the same edge; full is evaluated on the registered count.
- State machine:
  - IDLE:
    - ep_blockstrobe && ep_ready → BLOCK, words_left<=BLOCK_WORDS.
    - ep_blockstrobe && !ep_ready: strobe is ignored, protocol_err is set, state stays IDLE.
    - ep_read in IDLE: protocol_err is set and the read is still serviced per the read rules.
  - BLOCK:
    - Each ep_read decrements words_left. When the decrement reaches 0, the state goes to IDLE on that edge.
    - ep_blockstrobe in BLOCK: protocol_err is set, state and words_left are unchanged.
- ep_ready:
  - Registered: ep_ready <= (next_state==IDLE) && (count_next ≥ BLOCK_WORDS).
  - It therefore drops on the edge that accepts the blockstrobe.
  - It can re-assert on the same edge as the last read of a block if enough data remains.
- Flags:
  - Sticky until clr_flags.
  - clr_flags has priority over a same-cycle set.
- Arithmetic:
  - Pointers are DEPTH_LOG2 bits.
  - count is DEPTH_LOG2+1 bits, so the value 2^DEPTH_LOG2 is representable.
  - words_left width is clog2(BLOCK_WORDS+1).

Test Plan:
- Basic block:
  - Stimulus: push 0..255, wait, pulse ep_blockstrobe, then 256 back-to-back ep_read.
  - Required: ep_ready=1 one cycle after the 256th write; ep_ready=0 the cycle after the strobe; ep_datain=0,1,…,255 each one cycle after its read; state IDLE and ep_ready=0 afterwards.
- Two blocks:
  - Stimulus: push 600 words (DEPTH_LOG2=10); run two block transfers.
  - Required: words 0..511 come out in order; count=88 at the end; ep_ready=0.
- Full/overflow:
  - Stimulus: push 1025 words with no reads.
  - Required: full=1 after 1024; overflow=1; count=1024. A subsequent 4 blocks return 0..1023 exactly; the dropped word never appears.
- Underflow/protocol:
  - Case 1: ep_read on an empty FIFO → underflow=1, ep_datain=0, count=0.
  - Case 2: strobe with count=10 → protocol_err=1, state IDLE.
  - Case 3: clr_flags → both flags return to 0.
- Simultaneous:
  - Stimulus: during a block, assert wr_en and ep_read on the same cycle for 50 cycles.
  - Required: count is constant; read order is preserved across pointer wrap at 1023→0.
- Reset mid-block:
  - Stimulus: assert reset after 100 of 256 reads.
  - Required: ep_ready, count and ep_datain are 0 immediately, without waiting for a clock edge. After release, pushing 256 new words restores ep_ready and the reads return the new data.
